ripple_carry_adder: RTL and testbench



---
 rtl/ripple_carry_adder.sv | 75 +++++++
 tb/tb_ripple_carry_adder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ripple_carry_adder.sv
// Structural N-bit ripple-carry adder with the {cout, sum} result registered.
// Define RCA_OVERFLOW_EN to add a registered two's-complement overflow flag (ovf).

// One gate-level full adder cell; p is the propagate term shared by sum and carry.
module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  logic g;
  logic t;

  xor u_xor_p  (p, a, b);
  xor u_xor_s  (s, p, ci);
  and u_and_g  (g, a, b);
  and u_and_t  (t, p, ci);
  or  u_or_co  (co, g, t);
endmodule

module ripple_carry_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
`ifdef RCA_OVERFLOW_EN
  ,
  output logic         ovf
`endif
);
  logic [N:0]   carry;
  logic [N-1:0] sum_comb;

  assign carry[0] = cin;

  // carry[i+1] of each cell feeds the next, so the critical path is cin to carry[N]
  for (genvar i = 0; i < N; i++) begin : g_bit
    rca_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum_comb[i]),
      .co (carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_comb;
      cout <= carry[N];
    end
  end

`ifdef RCA_OVERFLOW_EN
  // Signed overflow: carry into the sign bit disagrees with carry out of it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else begin
      ovf <= carry[N] ^ carry[N-1];
    end
  end
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder: directed literal cases plus
// randomized operands compared every cycle against an arithmetic reference model.
module tb_ripple_carry_adder;
  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic [N-1:0] sum;
  logic         cout;
`ifdef RCA_OVERFLOW_EN
  logic         ovf;
`endif

  int testCount = 0;
  int failCount = 0;

  logic [N-1:0] expSum;
  logic         expCout;
  logic         expOvf;
  logic         modelValid = 1'b0;

  ripple_carry_adder #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout)
`ifdef RCA_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operands seen at each edge
  always @(posedge clk) begin
    longint total;
    longint sa;
    longint sb;
    longint ss;
    if (!rst_n) begin
      expSum  <= '0;
      expCout <= 1'b0;
      expOvf  <= 1'b0;
    end else begin
      total = longint'(a) + longint'(b) + longint'(cin);
      sa = (a >= (1 << (N-1))) ? longint'(a) - (longint'(1) << N) : longint'(a);
      sb = (b >= (1 << (N-1))) ? longint'(b) - (longint'(1) << N) : longint'(b);
      ss = sa + sb + longint'(cin);
      expSum  <= N'(total % (longint'(1) << N));
      expCout <= (total >= (longint'(1) << N));
      expOvf  <= (ss > (longint'(1) << (N-1)) - 1) || (ss < -(longint'(1) << (N-1)));
    end
    modelValid <= 1'b1;
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (modelValid) begin
      testCount++;
      if (sum !== expSum || cout !== expCout) begin
        failCount++;
        $display("[TB] FAIL model_cmp t=%0t: got sum=%h cout=%b, want sum=%h cout=%b",
                 $time, sum, cout, expSum, expCout);
      end
`ifdef RCA_OVERFLOW_EN
      testCount++;
      if (ovf !== expOvf) begin
        failCount++;
        $display("[TB] FAIL model_ovf t=%0t: got ovf=%b, want %b", $time, ovf, expOvf);
      end
`endif
    end
  end

  // Drive one operand set at a negedge and wait until the next negedge, after it is captured
  task automatic applyStimulus(input logic [N-1:0] sa, input logic [N-1:0] sb,
                               input logic sc, input logic srst);
    a     = sa;
    b     = sb;
    cin   = sc;
    rst_n = srst;
    @(negedge clk);
  endtask

  // Literal expectation checked against both the DUT and the model
  task automatic checkOutput(input string name, input logic [N-1:0] wSum,
                             input logic wCout, input logic wOvf);
    testCount++;
    if (sum !== wSum || cout !== wCout) begin
      failCount++;
      $display("[TB] FAIL %s: got sum=%h cout=%b, want sum=%h cout=%b",
               name, sum, cout, wSum, wCout);
    end
    testCount++;
    if (expSum !== wSum || expCout !== wCout || expOvf !== wOvf) begin
      failCount++;
      $display("[TB] FAIL %s_model: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
               name, expSum, expCout, expOvf, wSum, wCout, wOvf);
    end
`ifdef RCA_OVERFLOW_EN
    testCount++;
    if (ovf !== wOvf) begin
      failCount++;
      $display("[TB] FAIL %s_ovf: got ovf=%b, want %b", name, ovf, wOvf);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    a     = N'($urandom);
    b     = N'($urandom);
    cin   = 1'($urandom);
    @(negedge clk);

    applyStimulus(N'($urandom), N'($urandom), 1'($urandom), 1'b0);
    checkOutput("reset_1", 8'h00, 1'b0, 1'b0);
    applyStimulus(N'($urandom), N'($urandom), 1'($urandom), 1'b0);
    checkOutput("reset_2", 8'h00, 1'b0, 1'b0);

    applyStimulus(8'h01, 8'h00, 1'b1, 1'b1);
    checkOutput("add_01_00_c1", 8'h02, 1'b0, 1'b0);
    applyStimulus(8'h01, 8'h03, 1'b0, 1'b1);
    checkOutput("add_01_03", 8'h04, 1'b0, 1'b0);
    applyStimulus(8'h39, 8'h87, 1'b1, 1'b1);
    checkOutput("add_39_87_c1", 8'hC1, 1'b0, 1'b0);

    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1);
    checkOutput("wrap_ff_01_a", 8'h00, 1'b1, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1);
    checkOutput("wrap_ff_01_b", 8'h00, 1'b1, 1'b0);
    applyStimulus(8'hFF, 8'h81, 1'b1, 1'b1);
    checkOutput("wrap_ff_81_c1", 8'h81, 1'b1, 1'b0);

    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b1);
    checkOutput("ovf_7f_01", 8'h80, 1'b0, 1'b1);
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0);
    checkOutput("ovf_reset", 8'h00, 1'b0, 1'b0);
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b1);
    checkOutput("ovf_release", 8'h80, 1'b0, 1'b1);

    applyStimulus(8'h80, 8'h80, 1'b0, 1'b1);
    checkOutput("neg_ovf_80_80", 8'h00, 1'b1, 1'b1);
    applyStimulus(8'hFF, 8'h00, 1'b1, 1'b1);
    checkOutput("ripple_ff_00_c1", 8'h00, 1'b1, 1'b0);

    // Random operands with corner-biased values and occasional resets
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      case ($urandom_range(0, 5))
        0:       ra = '1;
        1:       ra = 8'h7F;
        default: ra = N'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       rb = '1;
        1:       rb = 8'h80;
        default: rb = N'($urandom);
      endcase
      applyStimulus(ra, rb, 1'($urandom), ($urandom_range(0, 19) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
